// File: rtl/f3m_mult_serial_pkg.sv
// f3m_mult_serial_pkg: GF(3^593) constants, trit arithmetic and the x-shift reduction mod p.
package f3m_mult_serial_pkg;
  localparam int M     = 593;
  localparam int WIDTH = 2*M-1;
  localparam int CNT_W = 10;
  localparam int TAP   = 112;
  localparam logic [1:0] F3_ZERO = 2'b00;
  localparam logic [1:0] F3_ONE  = 2'b01;
  localparam logic [1:0] F3_TWO  = 2'b10;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic logic [1:0] f3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction
  function automatic logic [1:0] f3_mult(input logic [1:0] x, input logic [1:0] y);
    return (x == F3_ZERO || y == F3_ZERO) ? F3_ZERO : ((x == y) ? F3_ONE : F3_TWO);
  endfunction
  // x^M == 2x^112 + 1, so the trit shifted out of the top folds back into trits 0 and 112
  function automatic logic [WIDTH:0] mod_p(input logic [WIDTH:0] acc);
    logic [1:0] t;
    logic [WIDTH:0] r;
    t = acc[WIDTH -: 2];
    r = {acc[WIDTH-2:0], F3_ZERO};
    r[1:0] = t;
    r[2*TAP +: 2] = f3_add(r[2*TAP +: 2], f3_add(t, t));
    return r;
  endfunction
endpackage

// File: rtl/f3m_mult_serial_if.sv
// f3m_mult_serial_if: start/done handshake and operand/result buses of the serial multiplier.
interface f3m_mult_serial_if;
  import f3m_mult_serial_pkg::*;
  logic start;
  logic busy;
  logic done;
  logic [WIDTH:0] a;
  logic [WIDTH:0] b;
  logic [WIDTH:0] c;
  modport master(output start, a, b, input busy, done, c);
  modport slave(input start, a, b, output busy, done, c);
endinterface

// File: rtl/f3m_mult_serial_scale_add.sv
// f3m_scale_add: acc_out = acc_in + s*a, trit by trit with no carries.
module f3m_scale_add import f3m_mult_serial_pkg::*; (
  input  logic [WIDTH:0] acc_in,
  input  logic [WIDTH:0] a,
  input  logic [1:0]     s,
  output logic [WIDTH:0] acc_out
);
  for (genvar g = 0; g < M; g++) begin : g_trit
    assign acc_out[2*g +: 2] = f3_add(acc_in[2*g +: 2], f3_mult(s, a[2*g +: 2]));
  end
endmodule

// File: rtl/f3m_mult_serial.sv
// f3m_mult_serial: bit-serial GF(3^593) multiplier, one B trit per clock, MSB first (Horner).
module f3m_mult_serial import f3m_mult_serial_pkg::*; (
  input logic clk,
  input logic reset_n,
  f3m_mult_serial_if.slave bus
);
  state_e state_q, state_d;
  logic [WIDTH:0] a_q, a_d, b_q, b_d, acc_q, acc_d, c_q, c_d, acc_x, acc_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  assign acc_x = mod_p(acc_q);
  f3m_scale_add u_scale_add (.acc_in(acc_x), .a(a_q), .s(b_q[WIDTH -: 2]), .acc_out(acc_next));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        a_d     = bus.a;
        b_d     = bus.b;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
    end else begin
      acc_d = acc_next;
      b_d   = b_q << 2;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(M-1)) begin
        c_d     = acc_next;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.c    = c_q;
endmodule

// File: tb/tb_f3m_mult_serial.sv
// tb_f3m_mult_serial: directed and model-checked tests of the serial GF(3^593) multiplier.
module tb_f3m_mult_serial;
  import f3m_mult_serial_pkg::*;
  typedef logic [WIDTH:0] bus_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  f3m_mult_serial_if ifc();
  f3m_mult_serial dut (.clk(clk), .reset_n(reset_n), .bus(ifc));
  always #5 clk = ~clk;

  function automatic bus_t one_at(input int i, input logic [1:0] v);
    bus_t r;
    r = '0;
    r[2*i +: 2] = v;
    return r;
  endfunction

  function automatic bus_t rand_bus();
    bus_t r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic int fd(input bus_t x, input bus_t y);
    for (int i = 0; i < M; i++) if (x[2*i +: 2] !== y[2*i +: 2]) return i;
    return 0;
  endfunction

  // schoolbook product, then fold degrees >= M down with x^M = 2x^112 + 1
  function automatic bus_t model(input bus_t a, input bus_t b);
    int p [2*M-1];
    int t;
    bus_t r;
    for (int i = 0; i < 2*M-1; i++) p[i] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        p[i+j] = (p[i+j] + int'(a[2*i +: 2]) * int'(b[2*j +: 2])) % 3;
    for (int d = 2*M-2; d >= M; d--) begin
      t = p[d];
      p[d] = 0;
      p[d-M+TAP] = (p[d-M+TAP] + 2*t) % 3;
      p[d-M] = (p[d-M] + t) % 3;
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(p[i]);
    return r;
  endfunction

  task automatic do_op(input bus_t a, input bus_t b, output bus_t res, output int lat,
                       output int busy_n, output logic done_after);
    @(negedge clk);
    ifc.a = a;
    ifc.b = b;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (ifc.done !== 1'b1 && lat < 2000) begin
      busy_n += int'(ifc.busy);
      @(posedge clk); #1;
      lat++;
    end
    res = ifc.c;
    @(posedge clk); #1;
    done_after = ifc.done;
  endtask

  task automatic test_reset();
    ifc.start = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifc.busy); end
    checks++;
    if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", ifc.done); end
    checks++;
    if (ifc.c !== '0) begin errors++; $display("FAIL reset_c trit %0d got %0d exp 0", fd(ifc.c, '0), ifc.c[2*fd(ifc.c, '0) +: 2]); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_one();
    bus_t res, e;
    int lat, bn, k;
    logic da;
    e = one_at(0, 2'b01);
    do_op(one_at(0, 2'b01), one_at(0, 2'b01), res, lat, bn, da);
    checks++;
    if (lat != M) begin errors++; $display("FAIL one_latency got %0d exp %0d", lat, M); end
    k = fd(res, e);
    checks++;
    if (res !== e) begin errors++; $display("FAIL one_c trit %0d got %0d exp %0d", k, res[2*k +: 2], e[2*k +: 2]); end
  endtask

  task automatic test_reduction();
    bus_t res, e;
    int lat, bn, k;
    logic da;
    e = one_at(0, 2'b01);
    e[2*TAP +: 2] = 2'b10;
    do_op(one_at(1, 2'b01), one_at(M-1, 2'b01), res, lat, bn, da);
    checks++;
    if (lat != M) begin errors++; $display("FAIL red_latency got %0d exp %0d", lat, M); end
    k = fd(res, e);
    checks++;
    if (res !== e) begin errors++; $display("FAIL red_c trit %0d got %0d exp %0d", k, res[2*k +: 2], e[2*k +: 2]); end
  endtask

  task automatic test_identity();
    bus_t res, e, ra;
    int lat, bn, k;
    logic da;
    e = one_at(0, 2'b01);
    do_op(one_at(0, 2'b10), one_at(0, 2'b10), res, lat, bn, da);
    k = fd(res, e);
    checks++;
    if (res !== e) begin errors++; $display("FAIL two_two trit %0d got %0d exp %0d", k, res[2*k +: 2], e[2*k +: 2]); end
    ra = rand_bus();
    e = '0;
    do_op(ra, '0, res, lat, bn, da);
    k = fd(res, e);
    checks++;
    if (res !== e) begin errors++; $display("FAIL times_zero trit %0d got %0d exp 0", k, res[2*k +: 2]); end
    ra = rand_bus();
    do_op(ra, one_at(0, 2'b01), res, lat, bn, da);
    k = fd(res, ra);
    checks++;
    if (res !== ra) begin errors++; $display("FAIL times_one trit %0d got %0d exp %0d", k, res[2*k +: 2], ra[2*k +: 2]); end
  endtask

  task automatic test_random();
    bus_t ra, rb, res, e;
    int lat, bn, k;
    logic da;
    for (int n = 0; n < 20; n++) begin
      ra = rand_bus();
      rb = rand_bus();
      e = model(ra, rb);
      do_op(ra, rb, res, lat, bn, da);
      k = fd(res, e);
      checks++;
      if (res !== e) begin errors++; $display("FAIL rand%0d_c trit %0d got %0d exp %0d", n, k, res[2*k +: 2], e[2*k +: 2]); end
      checks++;
      if (lat != M) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", n, lat, M); end
      checks++;
      if (bn != M) begin errors++; $display("FAIL rand%0d_busy_cycles got %0d exp %0d", n, bn, M); end
      checks++;
      if (da !== 1'b0) begin errors++; $display("FAIL rand%0d_done_pulse got %b exp 0", n, da); end
    end
  endtask

  task automatic test_back_to_back();
    bus_t e1, e2, res;
    int cyc, n_done, done_cyc, lat, k;
    e1 = one_at(0, 2'b01);
    e1[2*TAP +: 2] = 2'b10;
    @(negedge clk);
    ifc.a = one_at(1, 2'b01);
    ifc.b = one_at(M-1, 2'b01);
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    cyc = 0;
    n_done = 0;
    done_cyc = 0;
    while (cyc < M + 5) begin
      @(posedge clk); #1;
      cyc++;
      if (ifc.done === 1'b1) begin n_done++; done_cyc = cyc; res = ifc.c; end
      ifc.start = (cyc == 5 || cyc == 300);
      ifc.a = one_at(0, 2'b01);
      ifc.b = one_at(0, 2'b01);
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL ignore_start_dones got %0d exp 1", n_done); end
    checks++;
    if (done_cyc != M) begin errors++; $display("FAIL ignore_start_latency got %0d exp %0d", done_cyc, M); end
    k = fd(res, e1);
    checks++;
    if (res !== e1) begin errors++; $display("FAIL ignore_start_c trit %0d got %0d exp %0d", k, res[2*k +: 2], e1[2*k +: 2]); end
    @(negedge clk);
    ifc.a = one_at(0, 2'b01);
    ifc.b = one_at(0, 2'b01);
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    lat = 0;
    while (ifc.done !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    e1 = one_at(0, 2'b01);
    e2 = one_at(0, 2'b10);
    ifc.a = one_at(0, 2'b01);
    ifc.b = one_at(0, 2'b10);
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    checks++;
    if (ifc.busy !== 1'b1) begin errors++; $display("FAIL done_cycle_accept busy got %b exp 1", ifc.busy); end
    lat = 0;
    while (ifc.done !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 100) begin
        k = fd(ifc.c, e1);
        checks++;
        if (ifc.c !== e1) begin errors++; $display("FAIL c_held trit %0d got %0d exp %0d", k, ifc.c[2*k +: 2], e1[2*k +: 2]); end
      end
    end
    checks++;
    if (lat != M) begin errors++; $display("FAIL second_latency got %0d exp %0d", lat, M); end
    k = fd(ifc.c, e2);
    checks++;
    if (ifc.c !== e2) begin errors++; $display("FAIL second_c trit %0d got %0d exp %0d", k, ifc.c[2*k +: 2], e2[2*k +: 2]); end
  endtask

  task automatic test_abort();
    bus_t res, e;
    int lat, bn, k, n_done;
    logic da;
    @(negedge clk);
    ifc.a = rand_bus();
    ifc.b = rand_bus();
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (200) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", ifc.busy); end
    checks++;
    if (ifc.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", ifc.done); end
    checks++;
    if (ifc.c !== '0) begin errors++; $display("FAIL abort_c trit %0d got %0d exp 0", fd(ifc.c, '0), ifc.c[2*fd(ifc.c, '0) +: 2]); end
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    repeat (M + 10) begin
      @(posedge clk); #1;
      if (ifc.done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", n_done); end
    e = one_at(0, 2'b01);
    do_op(one_at(0, 2'b10), one_at(0, 2'b10), res, lat, bn, da);
    k = fd(res, e);
    checks++;
    if (res !== e) begin errors++; $display("FAIL after_abort_c trit %0d got %0d exp %0d", k, res[2*k +: 2], e[2*k +: 2]); end
    checks++;
    if (lat != M) begin errors++; $display("FAIL after_abort_latency got %0d exp %0d", lat, M); end
  endtask

  initial begin
    test_reset();
    test_one();
    test_reduction();
    test_identity();
    test_random();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
